// File: rtl/greedy_snake_pkg.sv
// Shared constants for the snake linked list in the Gowin DPB, used by the
// channel-A writer and the channel-B reader.
package greedy_snake_pkg;

  localparam logic [10:0] NULL_ADDRESS     = 11'd0;
  localparam logic [10:0] HEAD_ADDRESS     = 11'd4;
  localparam int          NODE_BYTES       = 4;

  localparam logic [1:0]  OFFSET_POS       = 2'd0;
  localparam logic [1:0]  OFFSET_RESERVED  = 2'd1;
  localparam logic [1:0]  OFFSET_NEXT_HI   = 2'd2;
  localparam logic [1:0]  OFFSET_NEXT_LO   = 2'd3;

  localparam logic [1:0]  FORWARD_UP       = 2'd0;
  localparam logic [1:0]  FORWARD_RIGHT    = 2'd1;
  localparam logic [1:0]  FORWARD_DOWN     = 2'd2;
  localparam logic [1:0]  FORWARD_LEFT     = 2'd3;

  localparam logic [7:0]  HEAD_POSITION_XY = 8'h44;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_FETCH,
    RD_WAIT,
    RD_EMIT,
    RD_FINISH
  } rd_state_e;

endpackage

// File: rtl/greedy_snake_node_fetch.sv
// Issues the four byte addresses of one list node and realigns the returning
// read data through the RD_LATENCY-deep memory pipeline.
module greedy_snake_node_fetch
  import greedy_snake_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic [10:0] base_addr,
  input  logic [7:0]  rd_data,
  output logic [10:0] rd_addr,
  output logic        issue_last,
  output logic        fetch_done,
  output logic [7:0]  node_pos,
  output logic [10:0] node_next
);

  logic        issue_active;
  logic [1:0]  issue_idx;
  logic [10:0] addr_r;
  logic [RD_LATENCY:1] tag_valid;
  logic [1:0]  tag_idx [RD_LATENCY:1];
  logic [7:0]  pos_r;
  logic [2:0]  next_hi_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_active <= 1'b0;
      issue_idx    <= 2'd0;
      addr_r       <= NULL_ADDRESS;
    end else if (fetch_start) begin
      issue_active <= 1'b1;
      issue_idx    <= OFFSET_POS;
      addr_r       <= base_addr;
    end else if (issue_active) begin
      if (issue_idx == OFFSET_NEXT_LO) begin
        issue_active <= 1'b0;
        addr_r       <= NULL_ADDRESS;
      end else begin
        issue_idx <= issue_idx + 2'd1;
        addr_r    <= addr_r + 11'd1;
      end
    end
  end

  // Each issued byte carries its offset down a tag pipe matching the read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      for (int i = 1; i <= RD_LATENCY; i++) tag_idx[i] <= 2'd0;
    end else begin
      tag_valid[1] <= issue_active;
      tag_idx[1]   <= issue_idx;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_idx[i]   <= tag_idx[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_r     <= 8'd0;
      next_hi_r <= 3'd0;
    end else if (tag_valid[RD_LATENCY]) begin
      if (tag_idx[RD_LATENCY] == OFFSET_POS)     pos_r     <= rd_data;
      if (tag_idx[RD_LATENCY] == OFFSET_NEXT_HI) next_hi_r <= rd_data[2:0];
    end
  end

  assign rd_addr    = addr_r;
  assign issue_last = issue_active && (issue_idx == OFFSET_NEXT_LO);
  assign fetch_done = tag_valid[RD_LATENCY] && (tag_idx[RD_LATENCY] == OFFSET_NEXT_LO);
  assign node_pos   = pos_r;
  assign node_next  = {next_hi_r, rd_data};

endmodule

// File: rtl/greedy_snake_dpb_r.sv
// Channel-B list walker: streams snake node positions head-first to the renderer.
// Optional head/body comparator enabled by GREEDY_SNAKE_COLLISION_CHECK_EN.
module greedy_snake_dpb_r
  import greedy_snake_pkg::*;
#(
  parameter int          RD_LATENCY = 2,
  parameter logic [10:0] MAX_NODES  = 11'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] head_addr,
  input  logic        writer_busy,
  output logic        busy,
  output logic        done,
  output logic        pos_valid,
  input  logic        pos_ready,
  output logic [7:0]  pos_data,
  output logic        pos_is_head,
  output logic [10:0] length,
  output logic        collision,
  output logic        overrun,
  output logic        stale,
  output logic        i_b_clk_en,
  output logic        i_b_data_en,
  output logic        i_b_wr_en,
  output logic [10:0] i_b_address,
  input  logic [7:0]  o_b_data
);

  rd_state_e   state, state_next;
  logic        fetch_start, issue_last, fetch_done;
  logic [7:0]  node_pos, pos_r;
  logic [10:0] node_next, next_r, fetch_base, length_r;
  logic        is_head_r, overrun_r, stale_r;
  logic        accept, handshake, walk_limit, last_node;

  greedy_snake_node_fetch #(.RD_LATENCY(RD_LATENCY)) u_fetch (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .base_addr   (fetch_base),
    .rd_data     (o_b_data),
    .rd_addr     (i_b_address),
    .issue_last  (issue_last),
    .fetch_done  (fetch_done),
    .node_pos    (node_pos),
    .node_next   (node_next)
  );

  assign accept     = (state == RD_IDLE) && start && !writer_busy;
  assign handshake  = (state == RD_EMIT) && pos_ready;
  assign walk_limit = (length_r + 11'd1) == MAX_NODES;
  assign last_node  = (next_r == NULL_ADDRESS) || walk_limit;
  assign fetch_base = (state == RD_IDLE) ? head_addr : next_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RD_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    fetch_start = 1'b0;
    case (state)
      RD_IDLE: begin
        if (accept) begin
          fetch_start = 1'b1;
          state_next  = RD_FETCH;
        end
      end
      RD_FETCH:  if (issue_last) state_next = RD_WAIT;
      RD_WAIT:   if (fetch_done) state_next = RD_EMIT;
      RD_EMIT: begin
        if (handshake) begin
          if (last_node) begin
            state_next = RD_FINISH;
          end else begin
            fetch_start = 1'b1;
            state_next  = RD_FETCH;
          end
        end
      end
      RD_FINISH: state_next = RD_IDLE;
      default:   state_next = RD_IDLE;
    endcase
  end

  // Length and flags are cleared on accept and otherwise hold for the consumer after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_r     <= 8'd0;
      next_r    <= NULL_ADDRESS;
      is_head_r <= 1'b0;
      length_r  <= 11'd0;
      overrun_r <= 1'b0;
      stale_r   <= 1'b0;
    end else begin
      if ((state == RD_WAIT) && fetch_done) begin
        pos_r  <= node_pos;
        next_r <= node_next;
      end
      if (accept) begin
        is_head_r <= 1'b1;
        length_r  <= 11'd0;
        overrun_r <= 1'b0;
        stale_r   <= 1'b0;
      end
      if (handshake) begin
        is_head_r <= 1'b0;
        length_r  <= length_r + 11'd1;
        if (walk_limit && (next_r != NULL_ADDRESS)) overrun_r <= 1'b1;
      end
      if (busy && writer_busy) stale_r <= 1'b1;
    end
  end

`ifdef GREEDY_SNAKE_COLLISION_CHECK_EN
  logic [7:0] head_pos_r;
  logic       collision_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_pos_r  <= 8'd0;
      collision_r <= 1'b0;
    end else if (accept) begin
      collision_r <= 1'b0;
    end else if (handshake) begin
      if (is_head_r)                 head_pos_r  <= pos_r;
      else if (pos_r == head_pos_r)  collision_r <= 1'b1;
    end
  end

  assign collision = collision_r;
`else
  assign collision = 1'b0;
`endif

  assign busy        = (state == RD_FETCH) || (state == RD_WAIT) || (state == RD_EMIT);
  assign done        = (state == RD_FINISH);
  assign pos_valid   = (state == RD_EMIT);
  assign pos_data    = pos_r;
  assign pos_is_head = is_head_r && (state == RD_EMIT);
  assign length      = length_r;
  assign overrun     = overrun_r;
  assign stale       = stale_r;
  assign i_b_clk_en  = 1'b1;
  assign i_b_data_en = 1'b1;
  assign i_b_wr_en   = 1'b0;

endmodule

// File: tb/tb_greedy_snake_dpb_r.sv
// Scoreboard bench for greedy_snake_dpb_r against a two-stage DPB read model.
module tb_greedy_snake_dpb_r;

  localparam logic [10:0] MAX_N = 11'd8;

  logic        clk, rst, start, writer_busy, pos_ready;
  logic [10:0] head_addr;
  logic        busy, done, pos_valid, pos_is_head, collision, overrun, stale;
  logic [7:0]  pos_data, o_b_data, mem_d1;
  logic [10:0] length, i_b_address;
  logic        i_b_clk_en, i_b_data_en, i_b_wr_en;

  greedy_snake_dpb_r #(.RD_LATENCY(2), .MAX_NODES(MAX_N)) dut (
    .clk(clk), .rst(rst), .start(start), .head_addr(head_addr),
    .writer_busy(writer_busy), .busy(busy), .done(done), .pos_valid(pos_valid),
    .pos_ready(pos_ready), .pos_data(pos_data), .pos_is_head(pos_is_head),
    .length(length), .collision(collision), .overrun(overrun), .stale(stale),
    .i_b_clk_en(i_b_clk_en), .i_b_data_en(i_b_data_en), .i_b_wr_en(i_b_wr_en),
    .i_b_address(i_b_address), .o_b_data(o_b_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipelined DPB channel B: data appears two cycles after the address.
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    mem_d1   <= mem[i_b_address];
    o_b_data <= mem_d1;
  end

  typedef struct { logic [7:0] pos; logic head; } pos_exp_t;
  typedef struct { logic [10:0] len; logic ovr; logic col; logic stl; } end_exp_t;

  pos_exp_t pos_q [$];
  end_exp_t end_q [$];
  pos_exp_t pe;
  end_exp_t ee;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cyc = 0;
  int walk_hs = 0;
  int ready_mode = 0;
  int low_cycles = 0;
  int start_cyc = 0;
  logic [10:0] last_len;
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_data;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: pops expectations on every handshake and every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (start && !busy && !done && !writer_busy) walk_hs = 0;
      if (pos_valid) begin
        checkOutput("no_refetch_addr", i_b_address, 0);
        if (stall_prev) checkOutput("hold_pos_data", pos_data, stall_data);
        if (pos_ready) begin
          if (pos_q.size() == 0) checkOutput("pos_expected", 0, 1);
          else begin
            pe = pos_q.pop_front();
            checkOutput("pos_data", pos_data, pe.pos);
            checkOutput("pos_is_head", pos_is_head, pe.head);
          end
          walk_hs++;
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          stall_data = pos_data;
        end
      end else begin
        stall_prev = 1'b0;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        if (end_q.size() == 0) checkOutput("done_expected", 0, 1);
        else begin
          ee = end_q.pop_front();
          checkOutput("length", length, ee.len);
          checkOutput("overrun", overrun, ee.ovr);
          checkOutput("collision", collision, ee.col);
          checkOutput("stale", stale, ee.stl);
          checkOutput("busy_at_done", busy, 0);
        end
      end
    end
  end

  initial begin
    pos_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (walk_hs == 0) low_cycles = 0;
      case (ready_mode)
        1: pos_ready = ($urandom_range(0, 3) != 0);
        2: if (pos_valid && walk_hs == 1 && low_cycles < 5) begin
             pos_ready = 1'b0;
             low_cycles++;
           end else pos_ready = 1'b1;
        3: pos_ready = (walk_hs == 0);
        default: pos_ready = 1'b1;
      endcase
    end
  end

  task automatic setNode(input logic [10:0] a, input logic [7:0] p, input logic [10:0] nxt);
    mem[a]         = p;
    mem[a + 11'd1] = 8'($urandom);
    mem[a + 11'd2] = {5'($urandom), nxt[10:8]};
    mem[a + 11'd3] = nxt[7:0];
  endtask

  // Reference walk straight from the list rules: follow links until NULL or the node limit.
  task automatic modelWalk(input logic [10:0] head, input bit stl);
    logic [10:0] addr, nxt;
    logic [7:0]  p, hp;
    int          n;
    end_exp_t    r;
    addr = head; n = 0; hp = 8'd0;
    r.ovr = 1'b0; r.col = 1'b0; r.stl = stl;
    for (int guard = 0; guard < 4096; guard++) begin
      p = mem[addr];
      if (n == 0) hp = p;
      else if (p == hp) r.col = 1'b1;
      pos_q.push_back('{pos: p, head: (n == 0)});
      n++;
      nxt = {mem[addr + 11'd2][2:0], mem[addr + 11'd3]};
      if (nxt == 11'd0) break;
      if (n == int'(MAX_N)) begin
        r.ovr = 1'b1;
        break;
      end
      addr = nxt;
    end
`ifndef GREEDY_SNAKE_COLLISION_CHECK_EN
    r.col = 1'b0;
`endif
    r.len = 11'(n);
    last_len = r.len;
    end_q.push_back(r);
  endtask

  task automatic waitDone(input int d0);
    for (int i = 0; i < 2000 && done_count == d0; i++) @(posedge clk);
    checkOutput("walk_done", done_count - d0, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_once", done_count - d0, 1);
    checkOutput("length_hold", length, last_len);
    checkOutput("busy_after", busy, 0);
    checkOutput("pos_queue_drained", pos_q.size(), 0);
  endtask

  task automatic applyStimulus(input logic [10:0] head, input bit wb_pulse, input int mode);
    int d0;
    ready_mode = mode;
    modelWalk(head, wb_pulse);
    @(posedge clk);
    #1;
    d0 = done_count;
    head_addr = head;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    if (wb_pulse) begin
      repeat (2) @(posedge clk);
      #1 writer_busy = 1'b1;
      repeat (2) @(posedge clk);
      #1 writer_busy = 1'b0;
    end
    waitDone(d0);
  endtask

  task automatic buildChain(input int n, output logic [10:0] head);
    int base, stride;
    logic [10:0] a [0:15];
    logic [7:0] p;
    base = $urandom_range(0, 510);
    stride = 1 << $urandom_range(0, 5);
    for (int i = 0; i < n; i++) a[i] = 11'(4 * (1 + ((base + i * stride) % 511)));
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 4))
        0: p = 8'h44;
        1: p = 8'h34;
        2: p = 8'h35;
        3: p = 8'h24;
        default: p = 8'($urandom);
      endcase
      setNode(a[i], p, (i == n - 1) ? 11'd0 : a[i+1]);
    end
    head = a[0];
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [10:0] h;
    int d0;
    rst = 1'b1; start = 1'b0; writer_busy = 1'b0; head_addr = 11'd0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pos_valid", pos_valid, 0);
    checkOutput("rst_length", length, 0);
    checkOutput("rst_flags", {collision, overrun, stale}, 0);
    checkOutput("rst_ports", {i_b_clk_en, i_b_data_en, i_b_wr_en}, 3'b110);
    checkOutput("rst_address", i_b_address, 0);
    rst = 1'b0;

    $display("[TB] basic three-node walk");
    setNode(11'd4, 8'h44, 11'd8);
    setNode(11'd8, 8'h34, 11'd12);
    setNode(11'd12, 8'h24, 11'd0);
    applyStimulus(11'd4, 1'b0, 0);
    checkOutput("walk_cycles", done_cyc - start_cyc, 22);

    $display("[TB] backpressure on node 2");
    applyStimulus(11'd4, 1'b0, 2);

    $display("[TB] head/body collision list");
    setNode(11'd12, 8'h35, 11'd16);
    setNode(11'd16, 8'h44, 11'd0);
    applyStimulus(11'd4, 1'b0, 0);

    $display("[TB] self loop overrun");
    setNode(11'd4, 8'h5A, 11'd4);
    applyStimulus(11'd4, 1'b0, 0);
    checkOutput("loop_overrun", overrun, 1);

    $display("[TB] start while writer busy");
    writer_busy = 1'b1;
    start = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 checkOutput("ignored_start_busy", busy, 0);
    end
    start = 1'b0;
    writer_busy = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1 checkOutput("no_pending_start", busy, 0);
    end
    setNode(11'd4, 8'h44, 11'd8);
    setNode(11'd8, 8'h34, 11'd12);
    setNode(11'd12, 8'h24, 11'd0);
    applyStimulus(11'd4, 1'b1, 0);

    $display("[TB] reset during node 2");
    modelWalk(11'd4, 1'b0);
    ready_mode = 3;
    @(posedge clk);
    #1 head_addr = 11'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 200 && !(pos_valid && walk_hs == 1); i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("reached_node2", pos_valid && walk_hs == 1, 1);
    d0 = done_count;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_pos_valid", pos_valid, 0);
    checkOutput("rst_mid_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pos_q.delete();
    end_q.delete();
    checkOutput("no_done_on_reset", done_count - d0, 0);
    checkOutput("rst_mid_length", length, 0);
    applyStimulus(11'd4, 1'b0, 0);

    $display("[TB] randomized walks");
    for (int t = 0; t < 30; t++) begin
      buildChain($urandom_range(1, 11), h);
      applyStimulus(h, ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
